// File: rtl/cache_control_pkg.sv
// Shared types for the LC-3b L1 cache controller and its tag store.
package cache_control_pkg;

    localparam int unsigned NUM_SETS = 8;
    localparam int unsigned TAG_W    = 9;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_cacheline;
    typedef logic [1:0]   lc3b_mem_wmask;

    typedef logic [8:0]   lc3b_c_tag;
    typedef logic [2:0]   lc3b_c_index;
    typedef logic [2:0]   lc3b_c_offset;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FILL      = 2'd2
    } cache_state_t;

endpackage

// File: rtl/cache_tag_array.sv
// Tag/valid/dirty store for one way; valid and dirty clear asynchronously,
// tags carry no reset since they are meaningless while valid is low.
module cache_tag_array #(
    parameter int unsigned NUM_SETS = 8,
    parameter int unsigned TAG_W    = 9,
    localparam int unsigned IDX_W   = $clog2(NUM_SETS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] index,
    input  logic             load,
    input  logic [TAG_W-1:0] tag_in,
    input  logic             set_dirty,
    input  logic             clr_dirty,
    output logic [TAG_W-1:0] tag_out,
    output logic             valid_out,
    output logic             dirty_out
);

    logic [NUM_SETS-1:0] valid;
    logic [NUM_SETS-1:0] dirty;
    logic [TAG_W-1:0]    tags [NUM_SETS];

    // Status bits: a line load makes the entry valid and clean.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
            dirty <= '0;
        end else if (load) begin
            valid[index] <= 1'b1;
            dirty[index] <= 1'b0;
        end else begin
            if (set_dirty) dirty[index] <= 1'b1;
            if (clr_dirty) dirty[index] <= 1'b0;
        end
    end

    // Tag storage, written only when a line is installed.
    always_ff @(posedge clk) begin
        if (load) tags[index] <= tag_in;
    end

    assign tag_out   = tags[index];
    assign valid_out = valid[index];
    assign dirty_out = dirty[index];

endmodule

// File: rtl/cache_control.sv
// Miss-handling FSM and LRU for the 2-way LC-3b L1 cache. Drives the
// data-array write enable / way select and the merge-stage pmem_read select.
module cache_control
    import cache_control_pkg::*;
#(
    parameter int unsigned NUM_SETS = 8,
    parameter int unsigned TAG_W    = 9
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] mem_address,
    input  logic        mem_read,
    input  logic        mem_write,
    output logic        mem_resp,
    input  logic        pmem_resp,
    output logic        pmem_read,
    output logic        pmem_write,
    output logic [15:0] pmem_address,
    output logic        way_sel,
    output logic        data_we,
    output logic        hit
);

    localparam int unsigned IDX_W = $clog2(NUM_SETS);

    cache_state_t        state;
    logic                victim;
    logic [NUM_SETS-1:0] lru;

    logic [TAG_W-1:0] addr_tag;
    logic [IDX_W-1:0] idx;
    logic             req;
    logic [TAG_W-1:0] tag0, tag1, vic_tag;
    logic             valid0, valid1, dirty0, dirty1;
    logic             match0, match1, hit_way, miss_dirty;
    logic             load_line, wb_done;
    logic             unused_offset;

    assign addr_tag      = mem_address[15 -: TAG_W];
    assign idx           = mem_address[4 +: IDX_W];
    assign unused_offset = ^mem_address[3:0];
    assign req           = mem_read | mem_write;

    assign match0     = valid0 && (tag0 == addr_tag);
    assign match1     = valid1 && (tag1 == addr_tag);
    assign hit_way    = match1;
    assign vic_tag    = victim ? tag1 : tag0;
    assign miss_dirty = lru[idx] ? (valid1 & dirty1) : (valid0 & dirty0);
    assign load_line  = (state == FILL) & pmem_resp;
    assign wb_done    = (state == WRITEBACK) & pmem_resp;

    cache_tag_array #(.NUM_SETS(NUM_SETS), .TAG_W(TAG_W)) u_way0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .index     (idx),
        .load      (load_line & ~victim),
        .tag_in    (addr_tag),
        .set_dirty (hit & mem_write & ~hit_way),
        .clr_dirty (wb_done & ~victim),
        .tag_out   (tag0),
        .valid_out (valid0),
        .dirty_out (dirty0)
    );

    cache_tag_array #(.NUM_SETS(NUM_SETS), .TAG_W(TAG_W)) u_way1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .index     (idx),
        .load      (load_line & victim),
        .tag_in    (addr_tag),
        .set_dirty (hit & mem_write & hit_way),
        .clr_dirty (wb_done & victim),
        .tag_out   (tag1),
        .valid_out (valid1),
        .dirty_out (dirty1)
    );

    // Per-state output decode; hit and the zero-wait response exist only in IDLE.
    always_comb begin
        hit          = 1'b0;
        mem_resp     = 1'b0;
        data_we      = 1'b0;
        way_sel      = 1'b0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        case (state)
            IDLE: begin
                hit      = req & (match0 | match1);
                mem_resp = hit;
                data_we  = hit & mem_write;
                way_sel  = hit & hit_way;
            end
            WRITEBACK: begin
                pmem_write   = 1'b1;
                pmem_address = {vic_tag, idx, 4'h0};
                way_sel      = victim;
            end
            FILL: begin
                pmem_read    = 1'b1;
                pmem_address = {mem_address[15:4], 4'h0};
                way_sel      = victim;
                data_we      = pmem_resp;
            end
            default: ;
        endcase
    end

    // FSM, victim latch and LRU; the victim is frozen at miss detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            victim <= 1'b0;
            lru    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (hit) begin
                        lru[idx] <= ~hit_way;
                    end else if (req) begin
                        victim <= lru[idx];
                        state  <= miss_dirty ? WRITEBACK : FILL;
                    end
                end
                WRITEBACK: if (pmem_resp) state <= FILL;
                FILL:      if (pmem_resp) state <= IDLE;
                default:   state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_control.sv
// Self-checking bench for cache_control against a set/way table model.
module tb_cache_control;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] mem_address;
    logic        mem_read, mem_write, pmem_resp;
    logic        mem_resp, pmem_read, pmem_write, way_sel, data_we, hit;
    logic [15:0] pmem_address;

    int checks = 0;
    int errors = 0;

    bit       m_valid [2][8];
    bit       m_dirty [2][8];
    bit [8:0] m_tag   [2][8];
    bit       m_lru   [8];

    cache_control #(.NUM_SETS(8), .TAG_W(9)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mem_address  (mem_address),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_resp     (mem_resp),
        .pmem_resp    (pmem_resp),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .way_sel      (way_sel),
        .data_we      (data_we),
        .hit          (hit)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int w = 0; w < 2; w++)
            for (int s = 0; s < 8; s++) begin
                m_valid[w][s] = 1'b0;
                m_dirty[w][s] = 1'b0;
            end
        for (int s = 0; s < 8; s++) m_lru[s] = 1'b0;
    endtask

    function automatic int lookup(input logic [15:0] a);
        for (int w = 0; w < 2; w++)
            if (m_valid[w][a[6:4]] && m_tag[w][a[6:4]] == a[15:7]) return w;
        return -1;
    endfunction

    task automatic idle_outputs(input string name);
        check({name, "_resp"}, mem_resp, 0);
        check({name, "_pmem"}, {pmem_read, pmem_write}, 0);
        check({name, "_addr"}, pmem_address, 0);
        check({name, "_we"}, data_we, 0);
        check({name, "_way"}, way_sel, 0);
        check({name, "_hit"}, hit, 0);
    endtask

    // One CPU request, checked cycle by cycle against the model. wl/rl are the
    // writeback/fill latencies in cycles; drop releases the request during FILL.
    task automatic access(input logic [15:0] a, input bit rd, input bit wr,
                          input int wl, input int rl, input bit drop);
        int idx, w, v;
        bit wb;
        idx = int'(a[6:4]);
        w   = lookup(a);
        @(negedge clk);
        mem_address = a; mem_read = rd; mem_write = wr; pmem_resp = 1'b0;
        #1;
        if (w >= 0) begin
            check("hit", hit, 1);
            check("hit_resp", mem_resp, 1);
            check("hit_way", way_sel, w);
            check("hit_we", data_we, wr);
            check("hit_pmem", {pmem_read, pmem_write}, 0);
            m_lru[idx] = (w == 0);
            if (wr) m_dirty[w][idx] = 1'b1;
        end else begin
            v  = m_lru[idx];
            wb = m_valid[v][idx] && m_dirty[v][idx];
            check("miss_hit", hit, 0);
            check("miss_resp", mem_resp, 0);
            check("miss_pmem", {pmem_read, pmem_write}, 0);
            if (wb) begin
                for (int i = 0; i < wl; i++) begin
                    @(negedge clk);
                    pmem_resp = (i == wl - 1);
                    #1;
                    check("wb_req", {pmem_read, pmem_write}, 2'b01);
                    check("wb_addr", pmem_address, {m_tag[v][idx], a[6:4], 4'h0});
                    check("wb_way", way_sel, v);
                    check("wb_resp", mem_resp, 0);
                    check("wb_we", data_we, 0);
                end
                m_dirty[v][idx] = 1'b0;
            end
            for (int i = 0; i < rl; i++) begin
                @(negedge clk);
                pmem_resp = (i == rl - 1);
                if (drop && i == 0) begin mem_read = 1'b0; mem_write = 1'b0; end
                #1;
                check("fill_req", {pmem_read, pmem_write}, 2'b10);
                check("fill_addr", pmem_address, {a[15:4], 4'h0});
                check("fill_way", way_sel, v);
                check("fill_we", data_we, (i == rl - 1));
                check("fill_resp", mem_resp, 0);
            end
            m_valid[v][idx] = 1'b1;
            m_dirty[v][idx] = 1'b0;
            m_tag[v][idx]   = a[15:7];
            @(negedge clk);
            pmem_resp = 1'b0;
            #1;
            if (drop) begin
                idle_outputs("drop");
            end else begin
                check("post_hit", hit, 1);
                check("post_resp", mem_resp, 1);
                check("post_way", way_sel, v);
                check("post_we", data_we, wr);
                check("post_pmem", {pmem_read, pmem_write}, 0);
                m_lru[idx] = (v == 0);
                if (wr) m_dirty[v][idx] = 1'b1;
            end
        end
        @(negedge clk);
        mem_read = 1'b0; mem_write = 1'b0;
    endtask

    initial begin
        logic [15:0] a;
        int kind;
        rst_n = 1'b0; mem_address = '0; mem_read = 1'b0; mem_write = 1'b0; pmem_resp = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        idle_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        idle_outputs("after_reset");

        // Clean miss, read hit, write hit in set 3.
        access(16'h1230, 1, 0, 1, 3, 0);
        access(16'h1236, 1, 0, 1, 1, 0);
        access(16'h1232, 0, 1, 1, 1, 0);
        // Second way, LRU aging, clean victim, then dirty victim.
        access(16'h5230, 1, 0, 1, 2, 0);
        access(16'h1230, 1, 0, 1, 1, 0);
        access(16'h9230, 1, 0, 1, 2, 0);
        access(16'hD230, 1, 0, 3, 2, 0);

        // Reset in the middle of a fill.
        @(negedge clk);
        mem_address = 16'h2240; mem_read = 1'b1;
        @(negedge clk);
        #1;
        check("rstfill_req", pmem_read, 1);
        #1;
        rst_n = 1'b0;
        #1;
        idle_outputs("rstfill");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1; mem_read = 1'b0;
        access(16'h1230, 1, 0, 1, 2, 0);

        // Request withdrawn during the fill, then the line hits.
        access(16'h4450, 1, 0, 1, 2, 1);
        access(16'h4452, 1, 0, 1, 1, 0);

        // Stray pmem_resp while idle.
        @(negedge clk);
        pmem_resp = 1'b1;
        #1;
        idle_outputs("stray");
        @(negedge clk);
        pmem_resp = 1'b0;

        // Read and write together behave as a write.
        access(16'h4454, 1, 1, 1, 1, 0);

        for (int n = 0; n < 300; n++) begin
            a    = {7'h0, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15))};
            kind = $urandom_range(0, 2);
            access(a, kind != 1, kind != 0, $urandom_range(1, 4), $urandom_range(1, 4),
                   $urandom_range(0, 9) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
